// File: rtl/seg_scan_ctrl_param.sv
// seg_scan_ctrl_param: multiplexed common-anode 7-segment scan driver.
// Scans N_DIG digits, one at a time for DWELL_CYC cycles each, with a short
// all-off gap at the start of every dwell to suppress ghosting. Input data is
// snapshotted once per frame so a digit never changes value mid-frame.
// Features: hex decode, per-digit DP, blanking, blink, leading-zero suppression.
// Optional macro SEG_SCAN_BRIGHT_EN adds a bright[3:0] input that shortens the
// lit part of each dwell for 16-step brightness control.
module seg_scan_ctrl_param #(
    parameter int N_DIG        = 8,
    parameter int DWELL_CYC    = 100000,
    parameter int GAP_CYC      = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 display_en,
    input  logic [4*N_DIG-1:0]   data,
    input  logic [N_DIG-1:0]     dp,
    input  logic [N_DIG-1:0]     blank,
    input  logic [N_DIG-1:0]     blink,
    input  logic                 lz_sup,
`ifdef SEG_SCAN_BRIGHT_EN
    input  logic [3:0]           bright,
`endif
    output logic [N_DIG-1:0]     led_en,
    output logic [7:0]           led_cx,
    output logic                 frame_tick
);

    localparam int CNT_W = $clog2(DWELL_CYC);
    localparam int IDX_W = $clog2(N_DIG);
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    // Scan position
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               dwell_wrap;
    logic               snap_take;

    // One-shot request for the snapshot right after reset release
    logic               init_q, init_d;

    // Blink state
    logic [BLK_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic               phase_q, phase_d;

    // Frame snapshot
    logic [4*N_DIG-1:0] snap_data_q, snap_data_d;
    logic [N_DIG-1:0]   snap_dp_q, snap_dp_d;
    logic [N_DIG-1:0]   snap_blank_q, snap_blank_d;
    logic [N_DIG-1:0]   snap_blink_q, snap_blink_d;
    logic               snap_lz_q, snap_lz_d;

    // Decode
    logic [N_DIG-1:0]   sup;
    logic               zero_run;
    logic [3:0]         cur_nib;
    logic               cur_dp;
    logic               cur_dark;
    logic               cur_sup;
    logic [7:0]         seg;
    logic               lit;

    // Registered outputs
    logic [N_DIG-1:0]   led_en_q, led_en_d;
    logic [7:0]         led_cx_q, led_cx_d;
    logic               frame_tick_q, frame_tick_d;

    // Active-low segment pattern for one hex nibble, DP bit left off
    function automatic logic [7:0] hex7(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'h03;
            4'h1: s = 8'h9F;
            4'h2: s = 8'h25;
            4'h3: s = 8'h0D;
            4'h4: s = 8'h99;
            4'h5: s = 8'h49;
            4'h6: s = 8'h41;
            4'h7: s = 8'h1F;
            4'h8: s = 8'h01;
            4'h9: s = 8'h09;
            4'hA: s = 8'h11;
            4'hB: s = 8'hC1;
            4'hC: s = 8'h63;
            4'hD: s = 8'h85;
            4'hE: s = 8'h61;
            default: s = 8'h71;
        endcase
        return s;
    endfunction

    // Dwell counter and digit index advance; frame starts when the index wraps
    always_comb begin
        dwell_wrap = (cnt_q == CNT_LAST);
        cnt_d      = cnt_q + 1'b1;
        idx_d      = idx_q;
        if (dwell_wrap) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        snap_take = init_q | (dwell_wrap & (idx_q == IDX_LAST));
        init_d    = 1'b0;
    end

    // Snapshot capture, frame tick and blink counting at each frame start
    always_comb begin
        snap_data_d  = snap_data_q;
        snap_dp_d    = snap_dp_q;
        snap_blank_d = snap_blank_q;
        snap_blink_d = snap_blink_q;
        snap_lz_d    = snap_lz_q;
        blk_cnt_d    = blk_cnt_q;
        phase_d      = phase_q;
        frame_tick_d = snap_take;
        if (snap_take) begin
            snap_data_d  = data;
            snap_dp_d    = dp;
            snap_blank_d = blank;
            snap_blink_d = blink;
            snap_lz_d    = lz_sup;
            if (blk_cnt_q == BLK_LAST) begin
                blk_cnt_d = '0;
                phase_d   = ~phase_q;
            end else begin
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
        end
    end

    // Leading-zero mask and segment pattern for the digit being scanned
    always_comb begin
        sup      = '0;
        zero_run = snap_lz_q;
        for (int k = N_DIG - 1; k >= 0; k--) begin
            zero_run = zero_run & (snap_data_q[4*k +: 4] == 4'h0);
            if (k != 0) sup[k] = zero_run;
        end
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        cur_dark = 1'b0;
        cur_sup  = 1'b0;
        for (int k = 0; k < N_DIG; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nib  = snap_data_q[4*k +: 4];
                cur_dp   = snap_dp_q[k];
                cur_dark = snap_blank_q[k] | (snap_blink_q[k] & phase_q);
                cur_sup  = sup[k];
            end
        end
        // A suppressed zero still shows its DP; blank/blink hide everything
        if (cur_dark) begin
            seg = 8'hFF;
        end else if (cur_sup) begin
            seg = {7'h7F, ~cur_dp};
        end else begin
            seg = hex7(cur_nib) & {7'h7F, ~cur_dp};
        end
    end

    // Lit window within the dwell, then next-cycle output values
    always_comb begin
        lit = display_en && (int'(cnt_q) >= GAP_CYC);
`ifdef SEG_SCAN_BRIGHT_EN
        lit = lit && (((int'(cnt_q) - GAP_CYC) * 16) <
                      ((int'(bright) + 1) * (DWELL_CYC - GAP_CYC)));
`endif
        led_en_d = '1;
        led_cx_d = 8'hFF;
        if (lit) begin
            led_en_d = ~(N_DIG'(1) << idx_q);
            led_cx_d = seg;
        end
    end

    // Scan position and blink state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            init_q    <= 1'b1;
            blk_cnt_q <= '0;
            phase_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            init_q    <= init_d;
            blk_cnt_q <= blk_cnt_d;
            phase_q   <= phase_d;
        end
    end

    // Frame snapshot registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_data_q  <= '0;
            snap_dp_q    <= '0;
            snap_blank_q <= '0;
            snap_blink_q <= '0;
            snap_lz_q    <= 1'b0;
        end else begin
            snap_data_q  <= snap_data_d;
            snap_dp_q    <= snap_dp_d;
            snap_blank_q <= snap_blank_d;
            snap_blink_q <= snap_blink_d;
            snap_lz_q    <= snap_lz_d;
        end
    end

    // Output registers, dark and deselected in reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_en_q     <= '1;
            led_cx_q     <= 8'hFF;
            frame_tick_q <= 1'b0;
        end else begin
            led_en_q     <= led_en_d;
            led_cx_q     <= led_cx_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign led_en     = led_en_q;
    assign led_cx     = led_cx_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl_param.sv
// Directed bench for seg_scan_ctrl_param: 4 digits, 4-cycle dwell, 1 gap cycle,
// 2-frame blink half-period. Each frame is walked cycle by cycle against
// hand-computed segment bytes. With SEG_SCAN_BRIGHT_EN a second instance
// checks the lit-cycle count for two brightness settings.
module tb_seg_scan_ctrl_param;

    localparam int N  = 4;
    localparam int DW = 4;
    localparam int GP = 1;
    localparam int BF = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          display_en;
    logic [15:0]   data;
    logic [3:0]    dp, blank, blink;
    logic          lz_sup;
    logic [3:0]    led_en;
    logic [7:0]    led_cx;
    logic          frame_tick;

    logic [15:0]   nxt_data;
    logic [3:0]    nxt_dp, nxt_blank, nxt_blink;
    logic          nxt_lz;

    int total = 0;
    int bad   = 0;

    // Clock
    always #5 clk = ~clk;

`ifdef SEG_SCAN_BRIGHT_EN
    logic [3:0] bright_b;
    logic [1:0] led_en_b;
    logic [7:0] led_cx_b;
    logic       frame_tick_b;

    seg_scan_ctrl_param #(
        .N_DIG(N), .DWELL_CYC(DW), .GAP_CYC(GP), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst(rst), .display_en(display_en), .data(data),
        .dp(dp), .blank(blank), .blink(blink), .lz_sup(lz_sup),
        .bright(4'hF),
        .led_en(led_en), .led_cx(led_cx), .frame_tick(frame_tick)
    );

    seg_scan_ctrl_param #(
        .N_DIG(2), .DWELL_CYC(34), .GAP_CYC(2), .BLINK_FRAMES(2)
    ) u_br (
        .clk(clk), .rst(rst), .display_en(display_en), .data(8'h88),
        .dp(2'b00), .blank(2'b00), .blink(2'b00), .lz_sup(1'b0),
        .bright(bright_b),
        .led_en(led_en_b), .led_cx(led_cx_b), .frame_tick(frame_tick_b)
    );
`else
    seg_scan_ctrl_param #(
        .N_DIG(N), .DWELL_CYC(DW), .GAP_CYC(GP), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst(rst), .display_en(display_en), .data(data),
        .dp(dp), .blank(blank), .blink(blink), .lz_sup(lz_sup),
        .led_en(led_en), .led_cx(led_cx), .frame_tick(frame_tick)
    );
`endif

    // Single comparison point
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic apply_next();
        data   = nxt_data;
        dp     = nxt_dp;
        blank  = nxt_blank;
        blink  = nxt_blink;
        lz_sup = nxt_lz;
    endtask

    // Walk one 16-cycle frame; exp holds segment bytes {d3,d2,d1,d0}.
    // With chg set, the nxt_* inputs are applied while digit 1 is shown.
    task automatic run_frame(input string name, input logic [31:0] exp,
                             input bit first, input bit chg);
        for (int s = 0; s < 16; s++) begin
            int         d;
            int         c;
            logic [3:0] exp_en;
            logic [7:0] exp_cx;
            logic       exp_tk;
            d = s / 4;
            c = s % 4;
            if (chg && s == 5) apply_next();
            @(posedge clk);
            #1;
            if (c < GP) begin
                exp_en = 4'hF;
                exp_cx = 8'hFF;
            end else begin
                exp_en = ~(4'b0001 << d);
                exp_cx = exp[8*d +: 8];
            end
            exp_tk = (s == 15) || (first && s == 0);
            chk($sformatf("%s s%0d en", name, s), {28'd0, led_en}, {28'd0, exp_en});
            chk($sformatf("%s s%0d cx", name, s), {24'd0, led_cx}, {24'd0, exp_cx});
            chk($sformatf("%s s%0d tick", name, s), {31'd0, frame_tick}, {31'd0, exp_tk});
        end
    endtask

    task automatic chk_dark(input string name, input bit tick_exp);
        chk($sformatf("%s en", name), {28'd0, led_en}, 32'hF);
        chk($sformatf("%s cx", name), {24'd0, led_cx}, 32'hFF);
        chk($sformatf("%s tick", name), {31'd0, frame_tick}, {31'd0, tick_exp});
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    // Main sequence
    initial begin
        rst = 1'b1;
        display_en = 1'b1;
        data = 16'h1A2F; dp = 4'h0; blank = 4'h0; blink = 4'h0; lz_sup = 1'b0;
`ifdef SEG_SCAN_BRIGHT_EN
        bright_b = 4'd3;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk_dark("reset", 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Plain hex decode, no suppression
        run_frame("t1f1", {8'h9F, 8'h11, 8'h25, 8'h71}, 1'b1, 1'b0);
        nxt_data = 16'h0007; nxt_dp = 4'b0100; nxt_blank = 4'h0; nxt_blink = 4'h0; nxt_lz = 1'b1;
        run_frame("t1f2", {8'h9F, 8'h11, 8'h25, 8'h71}, 1'b0, 1'b1);

        // Leading-zero suppression with DP on a suppressed digit
        nxt_data = 16'h1111; nxt_dp = 4'h0; nxt_lz = 1'b0;
        run_frame("t2", {8'hFF, 8'hFE, 8'hFF, 8'h1F}, 1'b0, 1'b1);

        // Mid-frame data change only appears after the next frame start
        nxt_data = 16'h2222;
        run_frame("t3a", {8'h9F, 8'h9F, 8'h9F, 8'h9F}, 1'b0, 1'b1);
        nxt_data = 16'h8888; nxt_blink = 4'b0001;
        run_frame("t3b", {8'h25, 8'h25, 8'h25, 8'h25}, 1'b0, 1'b1);

        // Blink: digit 0 off for two frames, on for two, off again
        run_frame("t4f1", {8'h01, 8'h01, 8'h01, 8'hFF}, 1'b0, 1'b0);
        run_frame("t4f2", {8'h01, 8'h01, 8'h01, 8'hFF}, 1'b0, 1'b0);
        run_frame("t4f3", {8'h01, 8'h01, 8'h01, 8'h01}, 1'b0, 1'b0);
        nxt_dp = 4'b0001; nxt_blank = 4'b0100;
        run_frame("t4f4", {8'h01, 8'h01, 8'h01, 8'h01}, 1'b0, 1'b1);
        nxt_data = 16'h0040; nxt_lz = 1'b1; nxt_blink = 4'h0; nxt_blank = 4'h0; nxt_dp = 4'h0;
        run_frame("t4f5", {8'h01, 8'hFF, 8'h01, 8'hFF}, 1'b0, 1'b1);

        // More suppression and the remaining hex glyphs
        nxt_data = 16'h0000;
        run_frame("lz40", {8'hFF, 8'hFF, 8'h99, 8'h03}, 1'b0, 1'b1);
        nxt_data = 16'h3456; nxt_lz = 1'b0;
        run_frame("lz00", {8'hFF, 8'hFF, 8'hFF, 8'h03}, 1'b0, 1'b1);
        nxt_data = 16'h7BCD;
        run_frame("hexa", {8'h0D, 8'h99, 8'h49, 8'h41}, 1'b0, 1'b1);
        nxt_data = 16'hE90F;
        run_frame("hexb", {8'h1F, 8'hC1, 8'h63, 8'h85}, 1'b0, 1'b1);
        run_frame("hexc", {8'h61, 8'h09, 8'h03, 8'h71}, 1'b0, 1'b0);

        // Display disabled for 10 cycles, then reset pulsed mid-dwell
        display_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk_dark($sformatf("t5 off%0d", i), 1'b0);
        end
        rst = 1'b1;
        #1;
        chk_dark("t5 rst", 1'b0);
        data = 16'h5A5A; blink = 4'hF; dp = 4'h0; blank = 4'h0; lz_sup = 1'b0;
        display_en = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_dark("t5 rsthold", 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        run_frame("t5f1", {8'h49, 8'h11, 8'h49, 8'h11}, 1'b1, 1'b0);
        run_frame("t5f2", {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 1'b0, 1'b0);

`ifdef SEG_SCAN_BRIGHT_EN
        // Brightness: 34-cycle dwell, 2 gap cycles, count lit cycles
        begin
            int lit_n;
            rst = 1'b1;
            bright_b = 4'd3;
            @(negedge clk);
            rst = 1'b0;
            lit_n = 0;
            for (int i = 0; i < 34; i++) begin
                @(posedge clk);
                #1;
                if (led_en_b != 2'b11) lit_n++;
            end
            chk("bright3 lit", lit_n, 32'd8);
            bright_b = 4'd15;
            lit_n = 0;
            for (int i = 0; i < 34; i++) begin
                @(posedge clk);
                #1;
                if (led_en_b != 2'b11) lit_n++;
            end
            chk("bright15 lit", lit_n, 32'd32);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
